mac_stream: RTL

Streaming signed multiply-accumulate stage that sits directly upstream of the single-value modular reducer. It accepts a vector of signed coefficient pairs, one pair per cycle, and accumulates a·b (or −a·b) over a configured number of terms. It emits one signed WW-bit dot-product per vector, with an overflow flag, on a valid/ready output. That output feeds the reducer's `in_val` unchanged.

---
 rtl/mac_stream_if.sv | 30 +++
 rtl/mac_stream.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mac_stream_if.sv
// Stream bundle between a coefficient-pair source, the mac_stream block
// and the downstream reducer that consumes the dot-product result.
interface mac_stream_if #(
    parameter int W     = 16,
    parameter int WW    = 2 * W,
    parameter int CNT_W = 7
);
    logic [CNT_W-1:0]     cfg_len;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  in_a;
    logic signed [W-1:0]  in_b;
    logic                 in_sub;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [WW-1:0] out_val;
    logic                 out_ovf;

    // Side that feeds coefficient pairs in and accepts results.
    modport master (
        output cfg_len, in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_val, out_ovf
    );

    // The accumulating block itself.
    modport slave (
        input  cfg_len, in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_val, out_ovf
    );
endinterface

// File: rtl/mac_stream.sv
// Streaming signed multiply-accumulate: one (a, b, sub) term per cycle,
// one WW-bit dot-product plus overflow flag per vector on a valid/ready port.
module mac_stream #(
    parameter int W     = 16,
    parameter int WW    = 2 * W,
    parameter int N_MAX = 64,
    parameter int CNT_W = $clog2(N_MAX + 1)
) (
    input logic         clk,
    input logic         reset,
    mac_stream_if.slave bus
);
    localparam int PW    = 2 * W;
    localparam int ACC_W = WW + CNT_W;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HOLD} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        len_q;
    logic [CNT_W-1:0]        count;
    logic signed [PW-1:0]    mult;
    logic signed [PW-1:0]    prod_p0;
    logic                    p_vld;
    logic signed [ACC_W-1:0] acc_p1;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] final_sum;
    logic                    fire;

    // Zero-length vectors still carry one term; oversize lengths clamp to N_MAX.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        if (len == '0)
            return CNT_W'(1);
        if (len > CNT_W'(N_MAX))
            return CNT_W'(N_MAX);
        return len;
    endfunction

    // Sum fits in WW signed bits only if the guard bits all copy the WW sign bit.
    function automatic logic ovf_of(input logic signed [ACC_W-1:0] sum);
        logic [CNT_W:0] top;
        top = sum[ACC_W-1:WW-1];
        return !((&top) || !(|top));
    endfunction

    assign fire      = bus.in_valid && bus.in_ready;
    assign mult      = PW'(bus.in_a) * PW'(bus.in_b);
    assign prod_ext  = {{(ACC_W - PW){prod_p0[PW-1]}}, prod_p0};
    assign final_sum = acc_p1 + prod_ext;

    // Stage P: register the (optionally negated) product of each accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_p0 <= '0;
            p_vld   <= 1'b0;
        end else begin
            p_vld <= fire;
            if (fire)
                prod_p0 <= bus.in_sub ? -mult : mult;
        end
    end

    // Stage A: accumulate products; FLUSH folds in the last product and loads the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_p1      <= '0;
            bus.out_val <= '0;
            bus.out_ovf <= 1'b0;
        end else begin
            if (state == IDLE && fire)
                acc_p1 <= '0;
            else if (state == ACCUM && p_vld)
                acc_p1 <= final_sum;
            if (state == FLUSH) begin
                bus.out_val <= final_sum[WW-1:0];
                bus.out_ovf <= ovf_of(final_sum);
            end
        end
    end

    // Vector sequencing; in_ready and out_valid are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            len_q         <= '0;
            count         <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (fire) begin
                        len_q <= eff_len(bus.cfg_len);
                        count <= CNT_W'(1);
                        if (eff_len(bus.cfg_len) == CNT_W'(1)) begin
                            state        <= FLUSH;
                            bus.in_ready <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (fire) begin
                        count <= count + CNT_W'(1);
                        if (count + CNT_W'(1) == len_q) begin
                            state        <= FLUSH;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state         <= HOLD;
                    bus.out_valid <= 1'b1;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b0;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
